burst_mem_responder: RTL and testbench

Memory-side responder for the 4-beat, 64-bit burst protocol driven by the cache line adaptor toward main memory. It accepts line-aligned read or write requests, waits a fixed access latency, then streams or absorbs four 64-bit beats qualified by resp_o. It backs a small on-chip line array and serves as the synthesizable memory behind the adaptor in the mp2 system and its unit benches.

---
 rtl/burst_mem_responder_if.sv | 21 ++
 rtl/burst_mem_responder.sv | 111 +++++++++++
 tb/tb_burst_mem_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/burst_mem_responder_if.sv
// Initiator/responder bundle for the 4-beat, 64-bit line burst protocol.
// Signal suffixes are named from the responder's point of view.
interface burst_mem_responder_if;
  logic        read_i;
  logic        write_i;
  logic [31:0] address_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
  logic        busy_o;

  modport master (
    output read_i, write_i, address_i, burst_i,
    input  burst_o, resp_o, busy_o
  );

  modport slave (
    input  read_i, write_i, address_i, burst_i,
    output burst_o, resp_o, busy_o
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Line-array memory answering 4-beat bursts after a fixed latency.
// Latency: LATENCY cycles to first beat; requests held after the burst are parked in DONE.
module burst_mem_responder #(
  parameter int NUM_LINES = 16,
  parameter int LATENCY   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  burst_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} state_t;

  state_t             state_q, state_d;
  logic               op_rd_q, op_rd_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [1:0]         beat_q,  beat_d;
  logic [255:0]       line_q [NUM_LINES];
  logic               wr_en;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.address_i[31:5+IDX_W], bus.address_i[4:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_rd_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      op_rd_q <= op_rd_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_rd_d = op_rd_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (bus.read_i || bus.write_i) begin
          op_rd_d = bus.read_i;
          idx_d   = bus.address_i[5 +: IDX_W];
          cnt_d   = CNT_W'(LATENCY - 1);
          beat_d  = 2'd0;
          // A one-cycle latency skips WAIT so beat 0 follows acceptance directly.
          state_d = (LATENCY == 1) ? BEAT : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          beat_d  = 2'd0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.read_i && !bus.write_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.resp_o  = (state_q == BEAT);
    bus.busy_o  = (state_q != IDLE);
    bus.burst_o = '0;
    if (state_q == BEAT && op_rd_q) begin
      bus.burst_o = line_q[idx_q][{beat_q, 6'd0} +: 64];
    end
  end

  assign wr_en = (state_q == BEAT) && !op_rd_q;

  // Each write beat commits on its own edge; reset wipes the whole array.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        line_q[i] <= '0;
      end
    end else if (wr_en) begin
      line_q[idx_q][{beat_q, 6'd0} +: 64] <= bus.burst_i;
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder at LATENCY 4 and LATENCY 1.
module tb_burst_mem_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  burst_mem_responder_if bus4();
  burst_mem_responder_if bus1();

  burst_mem_responder #(.NUM_LINES(16), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4.slave)
  );
  burst_mem_responder #(.NUM_LINES(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
  );

  int n_pass = 0;
  int n_tot  = 0;

  localparam logic [255:0] W_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] D_LINE = {64'hDEAD_BEEF_0000_0004, 64'hCAFE_F00D_0000_0003,
                                     64'h0123_4567_89AB_CDEF, 64'hA5A5_5A5A_0000_0001};
  localparam logic [255:0] E_LINE = {64'h0E0E_0000_0000_0004, 64'h0E0E_0000_0000_0003,
                                     64'h0E0E_0000_0000_0002, 64'h0E0E_0000_0000_0001};
  localparam logic [255:0] J_LINE = {4{64'hFFFF_0000_FFFF_0000}};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit l1, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [63:0] d);
    if (l1) begin
      bus1.read_i = rd; bus1.write_i = wr; bus1.address_i = a; bus1.burst_i = d;
    end else begin
      bus4.read_i = rd; bus4.write_i = wr; bus4.address_i = a; bus4.burst_i = d;
    end
  endtask

  function automatic logic get_resp(input bit l1);
    return l1 ? bus1.resp_o : bus4.resp_o;
  endfunction

  function automatic logic get_busy(input bit l1);
    return l1 ? bus1.busy_o : bus4.busy_o;
  endfunction

  function automatic logic [63:0] get_burst(input bit l1);
    return l1 ? bus1.burst_o : bus4.burst_o;
  endfunction

  // Runs one burst; first is the cycle index of beat 0 counted from the acceptance edge.
  task automatic xfer(input bit l1, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [255:0] wd, input int hold,
                      output logic [255:0] rdat, output int first, output int nresp,
                      output logic busy_hold, output logic busy_after);
    rdat = '0; first = -1; nresp = 0; busy_hold = 1'b1;
    drive(l1, rd, wr, a, 64'h0);
    for (int c = 1; c <= 40 && nresp < 4; c++) begin
      step;
      if (get_resp(l1)) begin
        if (first < 0) first = c;
        rdat[nresp*64 +: 64] = get_burst(l1);
        drive(l1, rd, wr, a, wd[nresp*64 +: 64]);
        nresp++;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      step;
      if (get_resp(l1)) nresp++;
      busy_hold &= get_busy(l1);
    end
    drive(l1, 1'b0, 1'b0, a, 64'h0);
    step;
    busy_after = get_busy(l1);
  endtask

  logic [255:0] rd_line;
  int           first, nresp;
  logic         bh, ba;

  task automatic test_reset;
    reset_n = 1'b0;
    step; step;
    reset_n = 1'b1;
    n_tot++; if (bus4.resp_o !== 1'b0) $display("FAIL reset_resp4 got %b want 0", bus4.resp_o); else n_pass++;
    n_tot++; if (bus4.busy_o !== 1'b0) $display("FAIL reset_busy4 got %b want 0", bus4.busy_o); else n_pass++;
    n_tot++; if (bus4.burst_o !== 64'h0) $display("FAIL reset_burst4 got %h want 0", bus4.burst_o); else n_pass++;
    n_tot++; if (bus1.busy_o !== 1'b0) $display("FAIL reset_busy1 got %b want 0", bus1.busy_o); else n_pass++;
  endtask

  task automatic test_read_zero;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0020, '0, 0, rd_line, first, nresp, bh, ba);
    n_tot++; if (first !== 4) $display("FAIL rz_first got %0d want 4", first); else n_pass++;
    n_tot++; if (nresp !== 4) $display("FAIL rz_nresp got %0d want 4", nresp); else n_pass++;
    n_tot++; if (rd_line !== 256'h0) $display("FAIL rz_data got %h want 0", rd_line); else n_pass++;
    n_tot++; if (bh !== 1'b1) $display("FAIL rz_busy_done got %b want 1", bh); else n_pass++;
    n_tot++; if (ba !== 1'b0) $display("FAIL rz_busy_after got %b want 0", ba); else n_pass++;
  endtask

  task automatic test_write_read;
    xfer(1'b0, 1'b0, 1'b1, 32'h0000_0040, W_LINE, 0, rd_line, first, nresp, bh, ba);
    n_tot++; if (nresp !== 4) $display("FAIL wr_nresp got %0d want 4", nresp); else n_pass++;
    n_tot++; if (rd_line !== 256'h0) $display("FAIL wr_burst_o got %h want 0", rd_line); else n_pass++;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0, 0, rd_line, first, nresp, bh, ba);
    for (int b = 0; b < 4; b++) begin
      n_tot++;
      if (rd_line[b*64 +: 64] !== W_LINE[b*64 +: 64])
        $display("FAIL wr_beat%0d got %h want %h", b, rd_line[b*64 +: 64], W_LINE[b*64 +: 64]);
      else n_pass++;
    end
  endtask

  task automatic test_alias;
    xfer(1'b0, 1'b0, 1'b1, 32'h0000_0060, D_LINE, 0, rd_line, first, nresp, bh, ba);
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0260, '0, 0, rd_line, first, nresp, bh, ba);
    n_tot++; if (rd_line !== D_LINE) $display("FAIL alias_hi got %h want %h", rd_line, D_LINE); else n_pass++;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_007F, '0, 0, rd_line, first, nresp, bh, ba);
    n_tot++; if (rd_line !== D_LINE) $display("FAIL alias_off got %h want %h", rd_line, D_LINE); else n_pass++;
  endtask

  task automatic test_rd_wr_both;
    xfer(1'b0, 1'b0, 1'b1, 32'h0000_00A0, E_LINE, 0, rd_line, first, nresp, bh, ba);
    xfer(1'b0, 1'b1, 1'b1, 32'h0000_00A0, J_LINE, 0, rd_line, first, nresp, bh, ba);
    n_tot++; if (rd_line !== E_LINE) $display("FAIL both_read got %h want %h", rd_line, E_LINE); else n_pass++;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_00A0, '0, 0, rd_line, first, nresp, bh, ba);
    n_tot++; if (rd_line !== E_LINE) $display("FAIL both_unchanged got %h want %h", rd_line, E_LINE); else n_pass++;
  endtask

  task automatic test_held_request;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0, 20, rd_line, first, nresp, bh, ba);
    n_tot++; if (nresp !== 4) $display("FAIL held_pulses got %0d want 4", nresp); else n_pass++;
    n_tot++; if (bh !== 1'b1) $display("FAIL held_busy got %b want 1", bh); else n_pass++;
    n_tot++; if (ba !== 1'b0) $display("FAIL held_release got %b want 0", ba); else n_pass++;
    n_tot++; if (rd_line !== W_LINE) $display("FAIL held_data got %h want %h", rd_line, W_LINE); else n_pass++;
  endtask

  task automatic test_reset_mid_write;
    int n;
    n = 0;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0040, 64'h0);
    for (int c = 1; c <= 40 && n < 3; c++) begin
      step;
      if (bus4.resp_o) begin
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0040, D_LINE[n*64 +: 64]);
        n++;
      end
    end
    n_tot++; if (n !== 3) $display("FAIL rst_mid_reach got %0d want 3", n); else n_pass++;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    step;
    n_tot++; if (bus4.resp_o !== 1'b0) $display("FAIL rst_mid_resp got %b want 0", bus4.resp_o); else n_pass++;
    n_tot++; if (bus4.busy_o !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", bus4.busy_o); else n_pass++;
    reset_n = 1'b1;
    step;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0, 0, rd_line, first, nresp, bh, ba);
    n_tot++; if (rd_line !== 256'h0) $display("FAIL rst_mid_clear got %h want 0", rd_line); else n_pass++;
    n_tot++; if (nresp !== 4) $display("FAIL rst_mid_nresp got %0d want 4", nresp); else n_pass++;
  endtask

  task automatic test_latency1;
    xfer(1'b1, 1'b0, 1'b1, 32'h0000_0040, W_LINE, 0, rd_line, first, nresp, bh, ba);
    n_tot++; if (first !== 1) $display("FAIL l1_wr_first got %0d want 1", first); else n_pass++;
    xfer(1'b1, 1'b1, 1'b0, 32'h0000_0040, '0, 0, rd_line, first, nresp, bh, ba);
    n_tot++; if (first !== 1) $display("FAIL l1_rd_first got %0d want 1", first); else n_pass++;
    n_tot++; if (nresp !== 4) $display("FAIL l1_nresp got %0d want 4", nresp); else n_pass++;
    n_tot++; if (rd_line !== W_LINE) $display("FAIL l1_data got %h want %h", rd_line, W_LINE); else n_pass++;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    test_reset;
    test_read_zero;
    test_write_read;
    test_alias;
    test_rd_wr_both;
    test_held_request;
    test_reset_mid_write;
    test_latency1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
